level_ctl: RTL and testbench
============================

# level_ctl

Scene sequencer placed between the per-scene background generators (menu, level 1, level 2) and the downstream VGA chain. It decides which scene is visible, advances the game through menu → level 1 → level 2 → end screen on player/game events, and runs a frame-synchronous fade-out/fade-in on every scene change. Scene and brightness change only at frame boundaries, so a visible frame never mixes two scenes or two brightness levels.

## Interface
- FADE_FRAMES, default 2: frames per brightness step (≥1).

- clk  in  1  system pixel clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: start/restart request
- level_done  in  1  one-cycle pulse: current level completed
- vga_menu  vga_if.in  –  menu scene stream
- vga_l1  vga_if.in  –  level 1 scene stream; also the timing master
- vga_l2  vga_if.in  –  level 2 scene stream
- vga_out  vga_if.out  –  selected, faded, registered stream
- scene  out  2  displayed scene: 0 MENU, 1 L1, 2 L2, 3 END
- busy  out  1  high while a fade is in progress

## Operation
- All three inputs come from the same timing source and are cycle-aligned. hcount/vcount/hsync/vsync/hblnk/vblnk are taken from vga_l1 only.
- frame_tick: one-cycle pulse when vga_l1.vblnk = 1 and its registered previous value = 0.
- Source rgb by scene:
  - MENU: vga_menu.rgb
  - L1: vga_l1.rgb
  - L2: vga_l2.rgb
  - END: bitwise ~vga_menu.rgb
- Brightness B, 5 bits, range 0..16. For each 4-bit channel c: out = (c × B) >> 4, using a 9-bit product. B = 16 is identity and B = 0 is black. Output rgb is forced to 0 when hblnk or vblnk is 1.
- FSM states: SHOW, FADE_OUT, FADE_IN.
- Registers: scene, next_scene, B, and the frame counter fcnt, which counts 0..FADE_FRAMES-1.
- step: frame_tick && fcnt == FADE_FRAMES-1. On any frame_tick in a fade state, fcnt wraps to 0 on step, else increments.
- SHOW:
  - start with scene ∈ {MENU, END} → next_scene = L1, fcnt = 0, go to FADE_OUT.
  - level_done with scene = L1 → next_scene = L2, go to FADE_OUT.
  - level_done with scene = L2 → next_scene = END, go to FADE_OUT.
  - All other events are ignored.
- FADE_OUT:
  - On step with B > 0: B = B−1.
  - On step with B = 0: scene = next_scene, go to FADE_IN.
- FADE_IN:
  - On step: B = B+1.
  - If B was 15, go to SHOW in the same cycle.
- start and level_done are ignored, not queued, in FADE_OUT and FADE_IN.
- If start and level_done arrive in the same cycle in SHOW, only the event valid for the current scene acts. The two are never both valid for one scene.
- busy = (state ≠ SHOW). The scene output mirrors the scene register.

## Timing
- vga_out lags the inputs by exactly 1 cycle: all seven fields are registered together.
- The scene and B updates take effect on the cycle after frame_tick, which falls inside vertical blanking. The first active pixel of the next frame uses the new values.
- Fade duration with N = FADE_FRAMES:
  - FADE_OUT lasts 17·N frame_ticks: 16 decrements plus 1 black hold step.
  - FADE_IN lasts 16·N frame_ticks.
- Reset values:
  - vga_out fields all 0.
  - scene = MENU, next_scene = MENU, B = 16, fcnt = 0.
  - State SHOW, busy = 0.
  - The frame_tick history register is 0.
- Reset asserted mid-fade aborts the fade immediately. The next cycle shows MENU at full brightness.

## Test plan
- Reset, then frames of MENU with menu rgb = 12'h123 in active area. Required: vga_out.rgb = 12'h123 one cycle later, rgb = 0 in blanking, scene = 0, busy = 0.
- FADE_FRAMES = 1, start pulse in MENU. Required:
  - busy = 1 next cycle.
  - After frame_tick 1, B = 15 and rgb 12'hFFF becomes 12'hEEE.
  - After ticks 16 and 17, rgb = 0 and then scene = 1.
  - After 16 further ticks, B = 16, busy = 0, and the output equals the vga_l1 rgb.
- In L1, pulse level_done → L2 after a full fade. In L2, pulse level_done → END, where menu rgb 12'h0F0 displays as 12'hF0F. In END, pulse start → L1.
- Ignored events:
  - level_done in MENU: no change.
  - start in L1: no change.
  - start or level_done mid-fade: the fade completes unchanged and nothing is queued.
- FADE_FRAMES = 3: B steps only every 3rd frame_tick. Check a total of 51 ticks out and 48 ticks in.
- Assert rst during FADE_OUT at B = 7. Required: the next cycle has scene = 0, B = 16, busy = 0, all vga_out fields 0, and normal pass-through resumes after rst deasserts.

Source files
------------

// File: rtl/level_ctl_if.sv
// VGA pixel stream bundle shared by the scene generators and the output chain.
// Producers connect through the out modport, consumers through in.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/level_ctl.sv
// Scene sequencer: picks the visible scene (menu, L1, L2, end) and runs a
// frame-synchronous fade-out/fade-in on each scene change.
module level_ctl #(
  parameter int FADE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       level_done,
  vga_if.in          vga_menu,
  vga_if.in          vga_l1,
  vga_if.in          vga_l2,
  vga_if.out         vga_out,
  output logic [1:0] scene,
  output logic       busy
);

  typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} state_t;
  typedef enum logic [1:0] {SC_MENU = 2'd0, SC_L1 = 2'd1, SC_L2 = 2'd2, SC_END = 2'd3} scene_t;

  localparam int              FW        = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [FW-1:0]   FCNT_LAST = FW'(FADE_FRAMES - 1);
  localparam logic [4:0]      B_FULL    = 5'd16;

  state_t        state_q, state_d;
  scene_t        scene_q, scene_d;
  scene_t        next_q, next_d;
  logic [4:0]    bright_q, bright_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          vblnk_q;

  logic frame_tick;
  logic step;

  assign frame_tick = vga_l1.vblnk & ~vblnk_q;
  assign step       = frame_tick && (fcnt_q == FCNT_LAST);

  // NOTE: every register here is updated with <= so all of them sample the
  // same pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SHOW;
      scene_q  <= SC_MENU;
      next_q   <= SC_MENU;
      bright_q <= B_FULL;
      fcnt_q   <= '0;
      vblnk_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      scene_q  <= scene_d;
      next_q   <= next_d;
      bright_q <= bright_d;
      fcnt_q   <= fcnt_d;
      vblnk_q  <= vga_l1.vblnk;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    scene_d  = scene_q;
    next_d   = next_q;
    bright_d = bright_q;
    fcnt_d   = fcnt_q;

    if (state_q != SHOW && frame_tick)
      fcnt_d = step ? '0 : FW'(fcnt_q + 1'b1);

    unique case (state_q)
      SHOW: begin
        fcnt_d = '0;
        if (start && (scene_q == SC_MENU || scene_q == SC_END)) begin
          next_d  = SC_L1;
          state_d = FADE_OUT;
        end else if (level_done && scene_q == SC_L1) begin
          next_d  = SC_L2;
          state_d = FADE_OUT;
        end else if (level_done && scene_q == SC_L2) begin
          next_d  = SC_END;
          state_d = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (step) begin
          if (bright_q != 5'd0) begin
            bright_d = bright_q - 5'd1;
          end else begin
            // Black hold step: the scene swaps while the screen is dark.
            scene_d = next_q;
            state_d = FADE_IN;
          end
        end
      end
      FADE_IN: begin
        if (step) begin
          bright_d = bright_q + 5'd1;
          if (bright_q == 5'd15)
            state_d = SHOW;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  function automatic logic [3:0] dim(input logic [3:0] c, input logic [4:0] b);
    logic [8:0] p;
    p = {5'd0, c} * {4'd0, b};
    return 4'(p >> 4);
  endfunction

  logic [11:0] src_rgb;
  logic [11:0] dim_rgb;

  always_comb begin
    src_rgb = vga_menu.rgb;
    unique case (scene_q)
      SC_MENU: src_rgb = vga_menu.rgb;
      SC_L1:   src_rgb = vga_l1.rgb;
      SC_L2:   src_rgb = vga_l2.rgb;
      SC_END:  src_rgb = ~vga_menu.rgb;
      default: src_rgb = vga_menu.rgb;
    endcase
    dim_rgb = {dim(src_rgb[11:8], bright_q),
               dim(src_rgb[7:4],  bright_q),
               dim(src_rgb[3:0],  bright_q)};
  end

  // Timing fields and pixel are registered together so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.hcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= vga_l1.vcount;
      vga_out.hcount <= vga_l1.hcount;
      vga_out.vsync  <= vga_l1.vsync;
      vga_out.hsync  <= vga_l1.hsync;
      vga_out.vblnk  <= vga_l1.vblnk;
      vga_out.hblnk  <= vga_l1.hblnk;
      vga_out.rgb    <= (vga_l1.hblnk || vga_l1.vblnk) ? 12'h000 : dim_rgb;
    end
  end

  assign scene = scene_q;
  assign busy  = (state_q != SHOW);

endmodule

// File: tb/tb_level_ctl.sv
// Bench for level_ctl: two instances (1 and 3 frames per step) against a
// fade-progress reference model, with a queue-based output scoreboard.
module tb_level_ctl;

  localparam int H_TOT = 16;
  localparam int H_ACT = 12;
  localparam int V_TOT = 8;
  localparam int V_ACT = 5;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int FADE_WAIT = 100 * FRAME;

  typedef struct packed {
    logic [11:0] rgb;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [1:0]  scene;
    logic        busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic level_done = 1'b0;
  always #5 clk = ~clk;

  vga_if menu_if();
  vga_if l1_if();
  vga_if l2_if();
  vga_if out1_if();
  vga_if out3_if();

  logic [1:0] scene1, scene3;
  logic       busy1, busy3;

  level_ctl #(.FADE_FRAMES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .level_done(level_done),
    .vga_menu(menu_if), .vga_l1(l1_if), .vga_l2(l2_if), .vga_out(out1_if),
    .scene(scene1), .busy(busy1)
  );

  level_ctl #(.FADE_FRAMES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .level_done(level_done),
    .vga_menu(menu_if), .vga_l1(l1_if), .vga_l2(l2_if), .vga_out(out3_if),
    .scene(scene3), .busy(busy3)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus: timing generator and pixel sources ----------
  int          h = H_TOT - 1;
  int          v = V_TOT - 1;
  int          mode = 1;
  logic [11:0] fix_menu = 12'h123;
  logic [11:0] fix_l1 = 12'hFFF;
  logic [11:0] fix_l2 = 12'h5A3;
  int          tick_cnt = 0;
  logic        drv_vb_prev = 1'b0;

  task automatic run_one(input logic s, input logic ld);
    logic hb, vb;
    @(negedge clk);
    h++;
    if (h == H_TOT) begin
      h = 0;
      v = (v == V_TOT - 1) ? 0 : v + 1;
    end
    hb = (h >= H_ACT);
    vb = (v >= V_ACT);
    if (vb && !drv_vb_prev) tick_cnt++;
    drv_vb_prev = vb;
    l1_if.hcount = 11'(h);   l1_if.vcount = 11'(v);
    l1_if.hblnk  = hb;       l1_if.vblnk  = vb;
    l1_if.hsync  = (h == H_ACT + 1);
    l1_if.vsync  = (v == V_ACT + 1);
    menu_if.hcount = 11'(h); menu_if.vcount = 11'(v);
    menu_if.hblnk  = hb;     menu_if.vblnk  = vb;
    menu_if.hsync  = l1_if.hsync; menu_if.vsync = l1_if.vsync;
    l2_if.hcount = 11'(h);   l2_if.vcount = 11'(v);
    l2_if.hblnk  = hb;       l2_if.vblnk  = vb;
    l2_if.hsync  = l1_if.hsync; l2_if.vsync = l1_if.vsync;
    if (mode == 0) begin
      menu_if.rgb = 12'($urandom);
      l1_if.rgb   = 12'($urandom);
      l2_if.rgb   = 12'($urandom);
    end else begin
      menu_if.rgb = fix_menu;
      l1_if.rgb   = fix_l1;
      l2_if.rgb   = fix_l2;
    end
    start      = s;
    level_done = ld;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_one(1'b0, 1'b0);
  endtask

  // ---------------- reference model ----------------------------------------
  // Fade progress is tracked as frame_ticks elapsed since the fade began.
  int   m_scene[2];
  int   m_next[2];
  int   m_ticks[2];
  bit   m_fading[2];
  int   nfr[2] = '{1, 3};
  logic m_vb_prev = 1'b0;
  obs_t q_exp[2][$];

  function automatic int exp_bright(input int i);
    int k;
    if (!m_fading[i]) return 16;
    if (m_ticks[i] < 17 * nfr[i]) begin
      k = m_ticks[i] / nfr[i];
      return (k >= 16) ? 0 : 16 - k;
    end
    return (m_ticks[i] - 17 * nfr[i]) / nfr[i];
  endfunction

  function automatic logic [11:0] scale_rgb(input logic [11:0] c, input int b);
    int r, g, bl;
    r  = (int'(c[11:8]) * b) / 16;
    g  = (int'(c[7:4])  * b) / 16;
    bl = (int'(c[3:0])  * b) / 16;
    return {4'(r), 4'(g), 4'(bl)};
  endfunction

  always @(posedge clk) begin
    obs_t        e;
    logic [11:0] src;
    logic        tick;
    tick = l1_if.vblnk && !m_vb_prev;
    for (int i = 0; i < 2; i++) begin
      e = '0;
      if (rst) begin
        m_scene[i] = 0; m_next[i] = 0; m_ticks[i] = 0; m_fading[i] = 0;
      end else begin
        case (m_scene[i])
          0:       src = menu_if.rgb;
          1:       src = l1_if.rgb;
          2:       src = l2_if.rgb;
          default: src = ~menu_if.rgb;
        endcase
        e.rgb    = (l1_if.hblnk || l1_if.vblnk) ? 12'h000 : scale_rgb(src, exp_bright(i));
        e.hcount = l1_if.hcount; e.vcount = l1_if.vcount;
        e.hsync  = l1_if.hsync;  e.vsync  = l1_if.vsync;
        e.hblnk  = l1_if.hblnk;  e.vblnk  = l1_if.vblnk;
        if (!m_fading[i]) begin
          if (start && (m_scene[i] == 0 || m_scene[i] == 3)) begin
            m_next[i] = 1; m_fading[i] = 1; m_ticks[i] = 0;
          end else if (level_done && (m_scene[i] == 1 || m_scene[i] == 2)) begin
            m_next[i] = m_scene[i] + 1; m_fading[i] = 1; m_ticks[i] = 0;
          end
        end else if (tick) begin
          m_ticks[i]++;
          if (m_ticks[i] == 17 * nfr[i]) m_scene[i] = m_next[i];
          if (m_ticks[i] == 33 * nfr[i]) m_fading[i] = 0;
        end
      end
      e.scene = 2'(m_scene[i]);
      e.busy  = m_fading[i];
      q_exp[i].push_back(e);
    end
    m_vb_prev = rst ? 1'b0 : l1_if.vblnk;
  end

  // ---------------- monitor -------------------------------------------------
  always @(negedge clk) begin
    obs_t a1, a3;
    a1 = {out1_if.rgb, out1_if.hcount, out1_if.vcount, out1_if.hsync,
          out1_if.vsync, out1_if.hblnk, out1_if.vblnk, scene1, busy1};
    a3 = {out3_if.rgb, out3_if.hcount, out3_if.vcount, out3_if.hsync,
          out3_if.vsync, out3_if.hblnk, out3_if.vblnk, scene3, busy3};
    if (q_exp[0].size() == 0 || q_exp[1].size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
    end else begin
      check("dut1_stream", 64'(a1), 64'(q_exp[0].pop_front()));
      check("dut3_stream", 64'(a3), 64'(q_exp[1].pop_front()));
    end
  end

  // ---------------- directed sequence ---------------------------------------
  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(1);
    check("reset_scene", 64'(scene1), 64'd0);
    check("reset_busy", 64'(busy1), 64'd0);
    run(2 * FRAME);

    run_one(1'b0, 1'b1);           // level_done in MENU is ignored
    run(FRAME);
    check("menu_ld_ignored_scene", 64'(scene1), 64'd0);
    check("menu_ld_ignored_busy", 64'(busy1), 64'd0);

    run_one(1'b1, 1'b0);           // start in MENU
    run(1);
    check("start_busy1", 64'(busy1), 64'd1);
    check("start_busy3", 64'(busy3), 64'd1);
    run(FADE_WAIT);
    check("to_l1_scene1", 64'(scene1), 64'd1);
    check("to_l1_busy1", 64'(busy1), 64'd0);
    check("to_l1_scene3", 64'(scene3), 64'd1);
    check("to_l1_busy3", 64'(busy3), 64'd0);

    mode = 0;
    run_one(1'b1, 1'b0);           // start in L1 is ignored
    run(FRAME);
    check("l1_start_ignored", 64'(scene1), 64'd1);
    check("l1_start_ignored_busy", 64'(busy1), 64'd0);

    run_one(1'b0, 1'b1);           // L1 -> L2, with events mid-fade
    run(5 * FRAME);
    run_one(1'b1, 1'b0);
    run(2);
    run_one(1'b0, 1'b1);
    run(FADE_WAIT);
    check("to_l2_scene1", 64'(scene1), 64'd2);
    check("to_l2_scene3", 64'(scene3), 64'd2);
    check("to_l2_busy1", 64'(busy1), 64'd0);

    mode = 1;
    fix_menu = 12'h0F0;
    run_one(1'b0, 1'b1);           // L2 -> END
    run(FADE_WAIT);
    check("to_end_scene1", 64'(scene1), 64'd3);
    check("to_end_scene3", 64'(scene3), 64'd3);
    while (!(h == 2 && v == 1)) run(1);
    run(1);
    check("end_inverted_rgb", 64'(out1_if.rgb), 64'h0F0F);

    mode = 0;
    run_one(1'b0, 1'b1);           // level_done in END is ignored
    run(FRAME);
    check("end_ld_ignored", 64'(scene1), 64'd3);
    run_one(1'b1, 1'b0);           // END -> L1
    run(FADE_WAIT);
    check("end_to_l1_scene1", 64'(scene1), 64'd1);
    check("end_to_l1_scene3", 64'(scene3), 64'd1);

    run_one(1'b0, 1'b1);           // begin fade, abort with reset at B = 7
    tick_cnt = 0;
    for (int i = 0; i < 20 * FRAME && tick_cnt < 9; i++) run(1);
    check("reached_nine_ticks", 64'(tick_cnt), 64'd9);
    run(3);
    check("bright_before_rst", 64'(dut1.bright_q), 64'd7);
    check("busy_before_rst", 64'(busy1), 64'd1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("rst_scene", 64'(scene1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_bright", 64'(dut1.bright_q), 64'd16);
    check("rst_out_fields", 64'({out1_if.rgb, out1_if.hcount, out1_if.vcount,
          out1_if.hsync, out1_if.vsync, out1_if.hblnk, out1_if.vblnk}), 64'd0);
    run(3 * FRAME);
    check("post_rst_scene", 64'(scene1), 64'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
